// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory slave for the core's DM port. Every load/store request is
// captured in IDLE, optionally held for LATENCY wait cycles, and answered with
// a one-cycle o_DM_data_ready strobe. Backing store is a word-organised RAM
// with byte-lane write enables.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_rst            synchronous reset, active-high
//   i_DM_Addr        byte address from the core
//   i_DM_Wd          store data, right-justified
//   i_DM_f3          access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   i_DM_Wen         store request
//   i_DM_MemRead     load request (both set = atomic swap)
//   o_DM_data_ready  one-cycle response strobe
//   o_DM_ReadData    load result, right-justified and extended
//   o_err            response carries an error (valid with data_ready)
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_DM_Addr,
  input  logic [31:0] i_DM_Wd,
  input  logic [2:0]  i_DM_f3,
  input  logic        i_DM_Wen,
  input  logic        i_DM_MemRead,
  output logic        o_DM_data_ready,
  output logic [31:0] o_DM_ReadData,
  output logic        o_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  f3_q, f3_d;
  logic        wen_q, wen_d;
  logic        rd_q, rd_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // The request being served. In IDLE this is the live input so that a
  // zero-latency access can be evaluated in its capture cycle; afterwards it
  // is the captured copy, which makes the block immune to input changes.
  logic        in_idle_s;
  logic [31:0] eff_addr_s;
  logic [2:0]  eff_f3_s;
  logic        eff_rd_s;
  logic [31:0] offset_s;
  logic [AW-1:0] idx_s;
  logic [1:0]  lane_s;
  logic        range_err_s;
  logic        fmt_err_s;
  logic        acc_err_s;
  logic [31:0] word_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ld_data_s;
  logic [3:0]  be_s;
  logic [31:0] st_data_s;
  logic        resp_load_s;
  logic        unused_s;

  assign in_idle_s  = (state_q == ST_IDLE);
  assign eff_addr_s = in_idle_s ? i_DM_Addr    : addr_q;
  assign eff_f3_s   = in_idle_s ? i_DM_f3      : f3_q;
  assign eff_rd_s   = in_idle_s ? i_DM_MemRead : rd_q;

  assign offset_s = eff_addr_s - BASE_ADDR;
  assign idx_s    = offset_s[AW+1:2];
  assign lane_s   = eff_addr_s[1:0];
  assign unused_s = ^{offset_s[31:AW+2], offset_s[1:0]};

  // 33-bit compare so a window ending at the top of the address space works.
  assign range_err_s = ({1'b0, eff_addr_s} < {1'b0, BASE_ADDR}) ||
                       ({1'b0, eff_addr_s} >= LIMIT);

  // Alignment and f3 legality of the served access.
  always_comb begin
    case (eff_f3_s)
      3'b000, 3'b100: fmt_err_s = 1'b0;
      3'b001, 3'b101: fmt_err_s = lane_s[0];
      3'b010:         fmt_err_s = (lane_s != 2'b00);
      default:        fmt_err_s = 1'b1;
    endcase
  end

  assign acc_err_s = range_err_s | fmt_err_s;

  assign word_s = mem[idx_s];
  assign byte_s = 8'(word_s >> {lane_s, 3'b000});
  assign half_s = lane_s[1] ? word_s[31:16] : word_s[15:0];

  // Load extraction with sign/zero extension.
  always_comb begin
    case (eff_f3_s)
      3'b000:  ld_data_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  ld_data_s = {{16{half_s[15]}}, half_s};
      3'b010:  ld_data_s = word_s;
      3'b100:  ld_data_s = {24'h00_0000, byte_s};
      3'b101:  ld_data_s = {16'h0000, half_s};
      default: ld_data_s = 32'h0000_0000;
    endcase
  end

  // Store lane enables and lane-replicated data, from the captured request.
  always_comb begin
    case (f3_q)
      3'b000: begin
        be_s      = 4'b0001 << lane_s;
        st_data_s = {4{wd_q[7:0]}};
      end
      3'b001: begin
        be_s      = lane_s[1] ? 4'b1100 : 4'b0011;
        st_data_s = {2{wd_q[15:0]}};
      end
      3'b010: begin
        be_s      = 4'b1111;
        st_data_s = wd_q;
      end
      default: begin
        be_s      = 4'b0000;
        st_data_s = 32'h0000_0000;
      end
    endcase
  end

  // Next-state and response logic of the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    f3_d        = f3_q;
    wen_d       = wen_q;
    rd_d        = rd_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    resp_load_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_DM_Wen | i_DM_MemRead) begin
          addr_d = i_DM_Addr;
          wd_d   = i_DM_Wd;
          f3_d   = i_DM_f3;
          wen_d  = i_DM_Wen;
          rd_d   = i_DM_MemRead;
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d     = ST_RESP;
            resp_load_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          resp_load_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // The core's request is still high here; it is deliberately not
        // re-captured.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Response registers are loaded on the edge entering RESP so they are
    // visible throughout the RESP cycle. The RAM word is read before the
    // store of the same transaction commits, giving swap semantics.
    if (resp_load_s) begin
      ready_d = 1'b1;
      err_d   = acc_err_s;
      if (acc_err_s) begin
        rdata_d = 32'h0000_0000;
      end else if (eff_rd_s) begin
        rdata_d = ld_data_s;
      end else begin
        rdata_d = 32'h0000_0000;
      end
    end else begin
      ready_d = 1'b0;
    end
  end

  // Sequencer state, captured request and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0000_0000;
      wd_q    <= 32'h0000_0000;
      f3_q    <= 3'b000;
      wen_q   <= 1'b0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM write: commits on the edge that ends RESP, unless reset aborts it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (state_q == ST_RESP) && wen_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= st_data_s[8*i +: 8];
        end
      end
    end
  end

  assign o_DM_data_ready = ready_q;
  assign o_DM_ReadData   = rdata_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 0, 1, 3) driven by a
// directed sequence. The driver pushes the expected response (cycle, data,
// error) into a per-instance queue; a monitor pops and compares on every
// data_ready strobe.
module tb_dmem_responder;

  typedef struct {
    int          cyc;
    logic        chk;
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_s   [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wd_s    [3];
  logic [2:0]  f3_s    [3];
  logic        wen_s   [3];
  logic        rd_s    [3];
  logic        ready_s [3];
  logic [31:0] rdata_s [3];
  logic        err_s   [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int cyc;
  int checks;
  int errors;

  dmem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .LATENCY(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst_s[0]), .i_DM_Addr(addr_s[0]), .i_DM_Wd(wd_s[0]),
    .i_DM_f3(f3_s[0]), .i_DM_Wen(wen_s[0]), .i_DM_MemRead(rd_s[0]),
    .o_DM_data_ready(ready_s[0]), .o_DM_ReadData(rdata_s[0]), .o_err(err_s[0]));

  dmem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst_s[1]), .i_DM_Addr(addr_s[1]), .i_DM_Wd(wd_s[1]),
    .i_DM_f3(f3_s[1]), .i_DM_Wen(wen_s[1]), .i_DM_MemRead(rd_s[1]),
    .o_DM_data_ready(ready_s[1]), .o_DM_ReadData(rdata_s[1]), .o_err(err_s[1]));

  dmem_responder #(.BASE_ADDR(32'h0), .DEPTH(1024), .LATENCY(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst_s[2]), .i_DM_Addr(addr_s[2]), .i_DM_Wd(wd_s[2]),
    .i_DM_f3(f3_s[2]), .i_DM_Wen(wen_s[2]), .i_DM_MemRead(rd_s[2]),
    .o_DM_data_ready(ready_s[2]), .o_DM_ReadData(rdata_s[2]), .o_err(err_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: value seen between two rising edges.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic void push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Monitor: compare each strobe against the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ready_s[k] === 1'b1) begin
        exp_t e;
        logic have;
        have = 1'b0;
        case (k)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_ready dut%0d cycle %0d data %h err %b", k, cyc, rdata_s[k], err_s[k]);
        end else begin
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s timing: ready in cycle %0d, required %0d", e.name, cyc, e.cyc);
          end
          checks++;
          if (err_s[k] !== e.err) begin
            errors++;
            $display("FAIL %s err: got %b, required %b", e.name, err_s[k], e.err);
          end
          if (e.chk) begin
            checks++;
            if (rdata_s[k] !== e.data) begin
              errors++;
              $display("FAIL %s data: got %h, required %h", e.name, rdata_s[k], e.data);
            end
          end
        end
      end
    end
  end

  // One access; optionally changes the address one cycle after capture.
  task automatic req_g(input int k, input logic wen, input logic rd, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic chk,
                       input logic [31:0] ed, input logic ee, input string nm,
                       input logic glitch, input logic [31:0] ga);
    exp_t e;
    logic got;
    @(negedge clk);
    addr_s[k] = a;
    wd_s[k]   = wd;
    f3_s[k]   = f3;
    wen_s[k]  = wen;
    rd_s[k]   = rd;
    e.cyc  = cyc + lat_of(k) + 1;
    e.chk  = chk;
    e.data = ed;
    e.err  = ee;
    e.name = nm;
    push(k, e);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (glitch && i == 0) addr_s[k] = ga;
      if (ready_s[k] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no data_ready within 20 cycles, required one", nm);
    end
    wen_s[k] = 1'b0;
    rd_s[k]  = 1'b0;
  endtask

  task automatic req(input int k, input logic wen, input logic rd, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic chk,
                     input logic [31:0] ed, input logic ee, input string nm);
    req_g(k, wen, rd, f3, a, wd, chk, ed, ee, nm, 1'b0, 32'h0);
  endtask

  task automatic check_idle_outputs(input int k, input string nm);
    checks++;
    if (ready_s[k] !== 1'b0 || rdata_s[k] !== 32'h0 || err_s[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready %b data %h err %b, required 0 00000000 0",
               nm, ready_s[k], rdata_s[k], err_s[k]);
    end
  endtask

  // Store whose WAIT cycle is hit by reset; no response must follow.
  task automatic abort_store(input int k, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    addr_s[k] = a;
    wd_s[k]   = wd;
    f3_s[k]   = 3'b010;
    wen_s[k]  = 1'b1;
    rd_s[k]   = 1'b0;
    @(negedge clk);
    rst_s[k]  = 1'b1;
    wen_s[k]  = 1'b0;
    @(negedge clk);
    rst_s[k]  = 1'b0;
    check_idle_outputs(k, "abort_reset_outputs");
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 3; k++) begin
      rst_s[k]  = 1'b1;
      addr_s[k] = 32'h0;
      wd_s[k]   = 32'h0;
      f3_s[k]   = 3'b000;
      wen_s[k]  = 1'b0;
      rd_s[k]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset_dut0");
    check_idle_outputs(1, "reset_dut1");
    check_idle_outputs(2, "reset_dut2");
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;

    // LATENCY = 1
    req(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "sw_10");
    req(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, "lw_10");
    req(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h11223344, 1'b0, 32'h0, 1'b0, "sw_20");
    req(1, 1'b1, 1'b0, 3'b000, 32'h22, 32'h000000AB, 1'b0, 32'h0, 1'b0, "sb_22");
    req(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b1, 32'h11AB3344, 1'b0, "lw_20_after_sb");
    req(1, 1'b0, 1'b1, 3'b000, 32'h22, 32'h0, 1'b1, 32'hFFFFFFAB, 1'b0, "lb_22");
    req(1, 1'b0, 1'b1, 3'b100, 32'h22, 32'h0, 1'b1, 32'h000000AB, 1'b0, "lbu_22");
    req(1, 1'b0, 1'b1, 3'b001, 32'h22, 32'h0, 1'b1, 32'h000011AB, 1'b0, "lh_22");
    req(1, 1'b0, 1'b1, 3'b010, 32'h21, 32'h0, 1'b1, 32'h0, 1'b1, "lw_21_misaligned");
    req(1, 1'b1, 1'b0, 3'b001, 32'h23, 32'h0000FFFF, 1'b1, 32'h0, 1'b1, "sh_23_misaligned");
    req(1, 1'b0, 1'b1, 3'b010, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b1, "lw_out_of_range");
    req(1, 1'b1, 1'b0, 3'b011, 32'h20, 32'h55555555, 1'b1, 32'h0, 1'b1, "illegal_f3_store");
    req(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b1, 32'h11AB3344, 1'b0, "lw_20_unchanged");
    req(1, 1'b1, 1'b0, 3'b010, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, "sw_last_word");
    req(1, 1'b0, 1'b1, 3'b010, 32'hFFC, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, "lw_last_word");
    req(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h5, 1'b0, 32'h0, 1'b0, "sw_30");
    req(1, 1'b1, 1'b1, 3'b010, 32'h30, 32'h9, 1'b1, 32'h5, 1'b0, "swap_30");
    req(1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h0, 1'b1, 32'h9, 1'b0, "lw_30_after_swap");
    req(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, "sw_40_zero");
    abort_store(1, 32'h40, 32'h12345678);
    req(1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, "lw_40_after_abort");

    // LATENCY = 0
    req(0, 1'b1, 1'b0, 3'b010, 32'h8, 32'h77, 1'b0, 32'h0, 1'b0, "l0_sw_8");
    req(0, 1'b0, 1'b1, 3'b010, 32'h8, 32'h0, 1'b1, 32'h00000077, 1'b0, "l0_lw_8");
    req(0, 1'b1, 1'b0, 3'b001, 32'hA, 32'h1234BEEF, 1'b0, 32'h0, 1'b0, "l0_sh_a");
    req(0, 1'b0, 1'b1, 3'b010, 32'h8, 32'h0, 1'b1, 32'hBEEF0077, 1'b0, "l0_lw_8_after_sh");
    req(0, 1'b0, 1'b1, 3'b001, 32'hA, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0, "l0_lh_a");
    req(0, 1'b0, 1'b1, 3'b101, 32'hA, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, "l0_lhu_a");
    req(0, 1'b0, 1'b1, 3'b000, 32'hB, 32'h0, 1'b1, 32'hFFFFFFBE, 1'b0, "l0_lb_b");

    // LATENCY = 3, with an address change during WAIT
    req(2, 1'b1, 1'b0, 3'b010, 32'h50, 32'h0000A5A5, 1'b0, 32'h0, 1'b0, "l3_sw_50");
    req(2, 1'b1, 1'b0, 3'b010, 32'h54, 32'h00005A5A, 1'b0, 32'h0, 1'b0, "l3_sw_54");
    req_g(2, 1'b0, 1'b1, 3'b010, 32'h50, 32'h0, 1'b1, 32'h0000A5A5, 1'b0,
          "l3_lw_50_addr_glitch", 1'b1, 32'h54);
    req(2, 1'b0, 1'b1, 3'b010, 32'h54, 32'h0, 1'b1, 32'h00005A5A, 1'b0, "l3_lw_54");

    repeat (6) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: %0d/%0d/%0d left, required 0/0/0",
               q0.size(), q1.size(), q2.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
